// File: rtl/ifft8_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifft8_input_buffer: ping-pong serial-to-parallel frame buffer feeding an |
// | 8-point IFFT. Optional macro IFFT8_IN_LAST_CHECK_EN adds s_last checking.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifft8_input_buffer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] s_real,
    input  logic signed [DATA_W-1:0] s_imag,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [DATA_W-1:0] a_real,
    output logic signed [DATA_W-1:0] a_imag,
    output logic signed [DATA_W-1:0] b_real,
    output logic signed [DATA_W-1:0] b_imag,
    output logic signed [DATA_W-1:0] c_real,
    output logic signed [DATA_W-1:0] c_imag,
    output logic signed [DATA_W-1:0] d_real,
    output logic signed [DATA_W-1:0] d_imag,
    output logic signed [DATA_W-1:0] e_real,
    output logic signed [DATA_W-1:0] e_imag,
    output logic signed [DATA_W-1:0] f_real,
    output logic signed [DATA_W-1:0] f_imag,
    output logic signed [DATA_W-1:0] g_real,
    output logic signed [DATA_W-1:0] g_imag,
    output logic signed [DATA_W-1:0] h_real,
    output logic signed [DATA_W-1:0] h_imag,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [15:0]              frame_cnt
`ifdef IFFT8_IN_LAST_CHECK_EN
    ,
    input  logic                     s_last,
    output logic                     frame_err
`endif
);

    localparam int                 c_IDX_W    = $clog2(FRAME_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);

    logic signed [DATA_W-1:0] r_re [2][FRAME_LEN];
    logic signed [DATA_W-1:0] r_im [2][FRAME_LEN];
    logic [1:0]               r_full;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [c_IDX_W-1:0]       r_wr_idx;
    logic [15:0]              r_frame_cnt;

    logic       w_accept;
    logic       w_xfer;
    logic       w_last_bad;
    logic       w_frame_done;
    logic [1:0] w_full_next;

    // rst_n gates s_ready so nothing is offered while the buffer is held in reset
    assign s_ready   = rst_n & ~r_full[r_wr_ptr];
    assign m_valid   = r_full[r_rd_ptr];
    assign w_accept  = s_valid & s_ready;
    assign w_xfer    = m_valid & m_ready;
    assign frame_cnt = r_frame_cnt;

`ifdef IFFT8_IN_LAST_CHECK_EN
    logic r_frame_err;

    assign w_last_bad = w_accept & (s_last != (r_wr_idx == c_LAST_IDX));
    assign frame_err  = r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else if (w_last_bad) begin
            r_frame_err <= 1'b1;
        end
    end
`else
    assign w_last_bad = 1'b0;
`endif

    assign w_frame_done = w_accept & (r_wr_idx == c_LAST_IDX) & ~w_last_bad;

    // Completing and draining always touch different banks: one is empty, the other full
    always_comb begin
        w_full_next = r_full;
        if (w_xfer) begin
            w_full_next[r_rd_ptr] = 1'b0;
        end
        if (w_frame_done) begin
            w_full_next[r_wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < FRAME_LEN; k++) begin
                    r_re[b][k] <= '0;
                    r_im[b][k] <= '0;
                end
            end
        end else if (w_accept) begin
            r_re[r_wr_ptr][r_wr_idx] <= s_real;
            r_im[r_wr_ptr][r_wr_idx] <= s_imag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full      <= 2'b00;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_wr_idx    <= '0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_full <= w_full_next;
            if (w_accept) begin
                r_wr_idx <= (w_frame_done || w_last_bad) ? '0 : r_wr_idx + 1'b1;
            end
            if (w_frame_done) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_xfer) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign a_real = r_re[r_rd_ptr][0];
    assign a_imag = r_im[r_rd_ptr][0];
    assign b_real = r_re[r_rd_ptr][1];
    assign b_imag = r_im[r_rd_ptr][1];
    assign c_real = r_re[r_rd_ptr][2];
    assign c_imag = r_im[r_rd_ptr][2];
    assign d_real = r_re[r_rd_ptr][3];
    assign d_imag = r_im[r_rd_ptr][3];
    assign e_real = r_re[r_rd_ptr][4];
    assign e_imag = r_im[r_rd_ptr][4];
    assign f_real = r_re[r_rd_ptr][5];
    assign f_imag = r_im[r_rd_ptr][5];
    assign g_real = r_re[r_rd_ptr][6];
    assign g_imag = r_im[r_rd_ptr][6];
    assign h_real = r_re[r_rd_ptr][7];
    assign h_imag = r_im[r_rd_ptr][7];

endmodule
`default_nettype wire

// File: doc/ifft8_input_buffer.md
IFFT8_INPUT_BUFFER -- requirements
Module: ifft8_input_buffer

Interface
REQ-001 Parameter DATA_W, default 32: width of each signed real/imag sample.
REQ-002 Parameter FRAME_LEN, fixed 8: samples per frame; other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_real  input  DATA_W  signed serial sample, real part.
REQ-006 s_imag  input  DATA_W  signed serial sample, imaginary part.
REQ-007 s_valid  input  1  serial sample present.
REQ-008 s_ready  output  1  buffer can accept a sample.
REQ-009 a_real,a_imag .. h_real,h_imag  output  DATA_W each  parallel frame, sample k on letter k (a=0 .. h=7), driving the 8-point IFFT inputs.
REQ-010 m_valid  output  1  parallel frame valid.
REQ-011 m_ready  input  1  downstream consumes frame.
REQ-012 frame_cnt  output  16  frames delivered since reset, wraps 65535->0.

Function
REQ-013 Two frame banks (ping-pong) of 8 complex samples each; one write bank, one read bank.
REQ-014 Sample accepted when s_valid && s_ready; written to write bank at index wr_idx (0..7), wr_idx then increments.
REQ-015 Accepting sample at wr_idx=7 marks write bank full, wr_idx->0, write pointer toggles.
REQ-016 s_ready = 1 iff the bank under the write pointer is empty; combinational from registered state only, never from s_valid.
REQ-017 m_valid = 1 iff the bank under the read pointer is full; a..h outputs driven from that bank.
REQ-018 Latency: m_valid rises the cycle after the 8th sample is accepted.
REQ-019 Frame transfer on m_valid && m_ready: read bank marked empty, read pointer toggles, frame_cnt increments.
REQ-020 While m_valid && !m_ready, a..h outputs and m_valid hold stable.
REQ-021 Simultaneous completion of a write frame and transfer of a read frame in the same cycle: both take effect; no sample or frame lost.
REQ-022 Both banks full: s_ready=0; samples stalled until a transfer frees a bank; s_ready returns the cycle after that transfer.
REQ-023 Sustained s_valid=1, m_ready=1: throughput one sample per cycle, one frame per 8 cycles, no bubbles.
REQ-024 Samples stored unmodified (no scaling, sign preserved); scaling is done downstream.
REQ-025 When the read bank is empty, a..h outputs are don't-care but shall not be X after reset.

Reset
REQ-026 rst_n low: wr_idx=0, both pointers=0, both banks empty, bank contents=0, m_valid=0, frame_cnt=0, all a..h=0.
REQ-027 s_ready driven 0 while rst_n low; 1 in first cycle after release.
REQ-028 Reset mid-frame discards the partial frame and any full, undelivered frames; no frame delivered after release until 8 new samples are accepted.

Configuration
REQ-029 Macro IFFT8_IN_LAST_CHECK_EN: when defined, adds input s_last (1) and output frame_err (1, sticky, reset 0).
REQ-030 With macro: s_last accepted with wr_idx!=7, or absent with wr_idx=7, sets frame_err, discards the partial frame (wr_idx->0, bank not marked full); s_last at a mismatch restarts at index 0 on the next sample.
REQ-031 Without macro: no s_last/frame_err ports; framing by count only.

Verification
REQ-032 Feed samples re=k+1, im=-(k+1), k=0..7, m_ready=1 -> m_valid one cycle after 8th accept; a_real=1, h_real=8, h_imag=-8; frame_cnt=1.
REQ-033 m_ready=0, 24 samples offered continuously -> 16 accepted, s_ready=0 from cycle 17; frame 1 held stable; m_ready=1 then releases frames in order.
REQ-034 Continuous streaming 80 samples, m_ready=1 -> 10 frames, s_ready never low, frame_cnt=10.
REQ-035 rst_n pulsed low after 5 samples -> outputs zero, m_valid=0; next 8 samples form frame with a_real equal to first post-reset sample.
REQ-036 Macro defined, s_last at index 3 -> frame_err=1, no frame delivered; next 8 samples with s_last at 7 -> valid frame, frame_err stays 1.
REQ-037 Sign edge: sample re=-2147483648, im=2147483647 at index 0 -> a_real/a_imag reproduce them bit-exact.
